// File: rtl/ex_stage_hs_if.sv
// Memory request/acknowledge bus between the execute stage and the data memory.
// The ack and read data arrive in the same cycle; the request side is registered.
interface ex_stage_hs_if #(parameter int DW = 16);
  logic          mem_req;
  logic          mem_we;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_in;
  logic          mem_ack;
  logic [DW-1:0] mem_out;

  modport master (output mem_req, mem_we, mem_addr, mem_in, input mem_ack, mem_out);
  modport slave  (input mem_req, mem_we, mem_addr, mem_in, output mem_ack, mem_out);
endinterface

// File: rtl/ex_stage_hs.sv
// Execute/memory stage with an ID valid/ready handshake, a variable-latency memory
// port, flush and a qualified combinational forwarding path.
module ex_stage_hs #(
  parameter int DW = 16,
  parameter int RW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  output logic          id_ready,
  input  logic          flush,
  input  logic [DW-1:0] areg,
  input  logic [DW-1:0] breg,
  input  logic [2:0]    com_id,
  input  logic [RW-1:0] rd_id,
  input  logic          rwe_id,
  input  logic          ld_op_id,
  input  logic          st_op_id,
  output logic          ex_valid,
  output logic [DW-1:0] creg,
  output logic [DW-1:0] dreg,
  output logic [RW-1:0] rd_ex,
  output logic          rwe_ex,
  output logic          ld_op_ex,
  output logic [DW-1:0] fwddata,
  output logic [RW-1:0] fwd_rd,
  output logic          fwd_valid,
  ex_stage_hs_if.master mem
);
  localparam int SW = $clog2(DW);

  typedef enum logic {IDLE, MEM_WAIT} state_t;
  typedef struct packed {
    logic [RW-1:0] rd;
    logic          rwe;
    logic          ld;
  } mop_t;

  state_t        state;
  mop_t          mop;
  logic          kill, req_q, we_q;
  logic [DW-1:0] addr_q, wdata_q, alu_out;
  logic          is_mem, accept, ack_live;

  assign is_mem   = ld_op_id | st_op_id;
  assign id_ready = (state == IDLE) & ~flush & ~rst;
  assign accept   = id_valid & id_ready;
  // a flush landing in the ack cycle itself discards the result like an earlier one
  assign ack_live = (state == MEM_WAIT) & mem.mem_ack & ~kill & ~flush & ~rst;

  assign mem.mem_req  = req_q;
  assign mem.mem_we   = we_q;
  assign mem.mem_addr = addr_q;
  assign mem.mem_in   = wdata_q;

  always_comb begin
    case (com_id)
      3'd0:    alu_out = areg + breg;
      3'd1:    alu_out = areg - breg;
      3'd2:    alu_out = areg & breg;
      3'd3:    alu_out = areg | breg;
      3'd4:    alu_out = areg ^ breg;
      3'd5:    alu_out = areg << breg[SW-1:0];
      3'd6:    alu_out = areg >> breg[SW-1:0];
      default: alu_out = breg;
    endcase
  end

  always_comb begin
    fwddata   = '0;
    fwd_rd    = '0;
    fwd_valid = 1'b0;
    if (ack_live && mop.ld) begin
      fwddata   = mem.mem_out;
      fwd_rd    = mop.rd;
      fwd_valid = mop.rwe;
    end else if (state == IDLE && id_valid && !flush && !rst && !is_mem) begin
      fwddata   = alu_out;
      fwd_rd    = rd_id;
      fwd_valid = rwe_id;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mop      <= '0;
      kill     <= 1'b0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      creg     <= '0;
      dreg     <= '0;
      rd_ex    <= '0;
      rwe_ex   <= 1'b0;
      ld_op_ex <= 1'b0;
      ex_valid <= 1'b0;
    end else begin
      ex_valid <= 1'b0;
      rwe_ex   <= 1'b0;
      ld_op_ex <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          if (is_mem) begin
            state   <= MEM_WAIT;
            req_q   <= 1'b1;
            we_q    <= st_op_id;
            addr_q  <= breg;
            wdata_q <= areg;
            mop     <= '{rd: rd_id, rwe: rwe_id, ld: ld_op_id};
            kill    <= 1'b0;
          end else begin
            creg     <= alu_out;
            rd_ex    <= rd_id;
            rwe_ex   <= rwe_id;
            ex_valid <= 1'b1;
          end
        end
        MEM_WAIT: begin
          if (flush) kill <= 1'b1;
          if (mem.mem_ack) begin
            state <= IDLE;
            req_q <= 1'b0;
            we_q  <= 1'b0;
            kill  <= 1'b0;
            if (!(kill || flush)) begin
              ex_valid <= 1'b1;
              rd_ex    <= mop.rd;
              if (mop.ld) begin
                dreg     <= mem.mem_out;
                ld_op_ex <= 1'b1;
                rwe_ex   <= mop.rwe;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ex_stage_hs.sv
// Scoreboard bench for ex_stage_hs: the driver models acceptance, memory timing and
// results at instruction level and queues expected completions; a monitor checks them.
module tb_ex_stage_hs;
  localparam int DW = 16;
  localparam int RW = 3;
  localparam int unsigned MOD = 1 << DW;

  logic clk, rst;
  logic id_valid, id_ready, flush;
  logic [DW-1:0] areg, breg;
  logic [2:0] com_id;
  logic [RW-1:0] rd_id;
  logic rwe_id, ld_op_id, st_op_id;
  logic ex_valid;
  logic [DW-1:0] creg, dreg, fwddata;
  logic [RW-1:0] rd_ex, fwd_rd;
  logic rwe_ex, ld_op_ex, fwd_valid;

  ex_stage_hs_if #(.DW(DW)) mif ();

  ex_stage_hs #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready), .flush(flush),
    .areg(areg), .breg(breg), .com_id(com_id), .rd_id(rd_id), .rwe_id(rwe_id),
    .ld_op_id(ld_op_id), .st_op_id(st_op_id), .ex_valid(ex_valid), .creg(creg),
    .dreg(dreg), .rd_ex(rd_ex), .rwe_ex(rwe_ex), .ld_op_ex(ld_op_ex),
    .fwddata(fwddata), .fwd_rd(fwd_rd), .fwd_valid(fwd_valid), .mem(mif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] creg;
    logic [DW-1:0] dreg;
    logic [RW-1:0] rd;
    logic          rwe;
    logic          ld;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0, n_err = 0;
  bit mon_en = 0;

  // instruction-level model state
  bit busy, killed, l_ld, l_st, l_rwe;
  int mem_left, next_lat;
  logic [DW-1:0] l_a, l_b, cur_creg, cur_dreg;
  logic [RW-1:0] l_rd;
  logic [DW-1:0] last_creg, last_dreg;
  logic [RW-1:0] last_rd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic logic [DW-1:0] alu_ref(input logic [2:0] op, input logic [DW-1:0] a, b);
    int unsigned x, y, r;
    x = a; y = b;
    case (op)
      3'd0: r = (x + y) % MOD;
      3'd1: r = (x + MOD - y) % MOD;
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      3'd5: r = (x << (y % DW)) % MOD;
      3'd6: r = x >> (y % DW);
      default: r = y;
    endcase
    return r[DW-1:0];
  endfunction

  // one clock of stimulus plus the combinational checks and model update for that cycle
  task automatic step(input logic v, input logic fl, input logic [2:0] op,
                      input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [RW-1:0] rd,
                      input logic rwe, input logic ld, input logic st,
                      input logic ack, input logic [DW-1:0] mout);
    logic [DW-1:0] alu;
    logic ackc;
    @(negedge clk);
    ackc = busy ? (mem_left == 1) : ack;
    id_valid = v; flush = fl; com_id = op; areg = a; breg = b; rd_id = rd;
    rwe_id = rwe; ld_op_id = ld; st_op_id = st;
    mif.mem_ack = ackc; mif.mem_out = mout;
    #1;
    alu = alu_ref(op, a, b);
    if (!busy) begin
      chk("id_ready_idle", id_ready, !fl);
      chk("mem_req_idle", {mif.mem_req, mif.mem_we}, 0);
      if (v && !fl && !(ld || st)) begin
        chk("fwd_valid_alu", fwd_valid, rwe);
        chk("fwddata_alu", fwddata, alu);
        if (rwe) chk("fwd_rd_alu", fwd_rd, rd);
      end else begin
        chk("fwd_valid_none", fwd_valid, 0);
        chk("fwddata_none", fwddata, 0);
      end
      if (v && !fl) begin
        if (ld || st) begin
          busy = 1; mem_left = next_lat; killed = 0;
          l_a = a; l_b = b; l_rd = rd; l_rwe = rwe; l_ld = ld; l_st = st;
        end else begin
          cur_creg = alu;
          exp_q.push_back('{cur_creg, cur_dreg, rd, rwe, 1'b0});
        end
      end
    end else begin
      chk("id_ready_wait", id_ready, 0);
      chk("mem_req_wait", mif.mem_req, 1);
      chk("mem_we", mif.mem_we, l_st);
      chk("mem_addr", mif.mem_addr, l_b);
      chk("mem_in", mif.mem_in, l_a);
      if (fl) killed = 1;
      if (ackc && l_ld && !killed) begin
        chk("fwd_valid_ld", fwd_valid, l_rwe);
        chk("fwddata_ld", fwddata, mout);
        if (l_rwe) chk("fwd_rd_ld", fwd_rd, l_rd);
      end else begin
        chk("fwd_valid_wait", fwd_valid, 0);
        chk("fwddata_wait", fwddata, 0);
      end
      if (ackc) begin
        busy = 0;
        if (!killed) begin
          if (l_ld) cur_dreg = mout;
          exp_q.push_back('{cur_creg, cur_dreg, l_rd, l_ld & l_rwe, l_ld});
        end
      end else begin
        mem_left--;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0);
  endtask

  task automatic do_reset(input int cyc);
    @(negedge clk);
    #1;
    mon_en = 0;
    rst = 1; id_valid = 1; ld_op_id = 1; st_op_id = 0; rwe_id = 1; flush = 0;
    mif.mem_ack = 1;
    for (int i = 0; i < cyc; i++) begin
      @(negedge clk);
      #1;
      chk("rst_id_ready", id_ready, 0);
      chk("rst_mem_req", mif.mem_req, 0);
      chk("rst_mem_we", mif.mem_we, 0);
      chk("rst_mem_addr", mif.mem_addr, 0);
      chk("rst_mem_in", mif.mem_in, 0);
      chk("rst_fwd_valid", fwd_valid, 0);
      chk("rst_ex_ctl", {ex_valid, rwe_ex, ld_op_ex}, 0);
      chk("rst_creg", creg, 0);
      chk("rst_dreg", dreg, 0);
      chk("rst_rd_ex", rd_ex, 0);
    end
    busy = 0; killed = 0; exp_q.delete();
    cur_creg = 0; cur_dreg = 0;
    last_creg = 0; last_dreg = 0; last_rd = 0;
    rst = 0; id_valid = 0; ld_op_id = 0; rwe_id = 0; mif.mem_ack = 0;
    mon_en = 1;
  endtask

  // monitor: registered outputs after each edge against the queued completions
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (ex_valid) begin
          if (exp_q.size() == 0) chk("unexpected_ex_valid", ex_valid, 0);
          else begin
            e = exp_q.pop_front();
            chk("creg", creg, e.creg);
            chk("dreg", dreg, e.dreg);
            chk("rd_ex", rd_ex, e.rd);
            chk("rwe_ex", rwe_ex, e.rwe);
            chk("ld_op_ex", ld_op_ex, e.ld);
            last_creg = e.creg; last_dreg = e.dreg; last_rd = e.rd;
          end
        end else begin
          chk("idle_ctl", {rwe_ex, ld_op_ex}, 0);
          chk("hold_creg", creg, last_creg);
          chk("hold_dreg", dreg, last_dreg);
          chk("hold_rd_ex", rd_ex, last_rd);
        end
      end
    end
  end

  initial begin
    rst = 1; id_valid = 0; flush = 0; areg = 0; breg = 0; com_id = 0; rd_id = 0;
    rwe_id = 0; ld_op_id = 0; st_op_id = 0; mif.mem_ack = 0; mif.mem_out = 0;
    next_lat = 1;
    do_reset(2);

    // back-to-back ALU stream with wrap and shift-amount masking
    step(1, 0, 3'd0, 16'hFFFF, 16'h0001, 3'd1, 1, 0, 0, 0, 0);
    step(1, 0, 3'd1, 16'h0000, 16'h0001, 3'd2, 0, 0, 0, 0, 0);
    step(1, 0, 3'd5, 16'h0001, 16'h0013, 3'd3, 1, 0, 0, 0, 0);
    step(1, 0, 3'd6, 16'h8000, 16'd15,   3'd4, 1, 0, 0, 0, 0);
    idle(1);

    // load with ack on the third wait cycle
    next_lat = 3;
    step(1, 0, 3'd0, 16'h0000, 16'h0040, 3'd5, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'hBEEF);
    // store with immediate ack, accepted right after the load completes
    next_lat = 1;
    step(1, 0, 3'd0, 16'h1234, 16'h0010, 3'd6, 1, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);

    // flush in the second wait cycle of a load
    next_lat = 3;
    step(1, 0, 3'd0, 16'h0000, 16'h0022, 3'd7, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h5555);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h6666);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h7777);
    idle(1);

    // flush with id_valid in IDLE, then the same op accepted
    step(1, 1, 3'd2, 16'h00F0, 16'h0FF0, 3'd1, 1, 0, 0, 0, 0);
    step(1, 0, 3'd2, 16'h00F0, 16'h0FF0, 3'd1, 1, 0, 0, 0, 0);
    idle(1);

    // reset in the middle of a memory wait abandons the access
    next_lat = 4;
    step(1, 0, 3'd0, 16'h0000, 16'h0100, 3'd2, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset(1);
    idle(2);

    for (int i = 0; i < 2000; i++) begin
      int k;
      k = $urandom_range(0, 5);
      next_lat = $urandom_range(1, 4);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, 3'($urandom_range(0, 7)),
           16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           k == 0, k == 1, 1'($urandom_range(0, 1)), 16'($urandom));
    end
    idle(8);
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
